// File: rtl/lsu_bus_ctrl_if.sv
// Data-bus bundle between the load/store controller (master) and memory (slave).
// One outstanding req/gnt transaction; reads complete with a separate rvalid beat.
interface lsu_bus_ctrl_if;
    localparam int CPU_WIDTH = 32;

    logic                 bus_req_o;
    logic                 bus_we_o;
    logic [CPU_WIDTH-1:0] bus_addr_o;
    logic [CPU_WIDTH-1:0] bus_wdata_o;
    logic [3:0]           bus_wstrb_o;
    logic                 bus_gnt_i;
    logic                 bus_rvalid_i;
    logic [CPU_WIDTH-1:0] bus_rdata_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i
    );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// Memory-stage load/store controller: one bus transaction per access instruction,
// holding the pipeline until the store is granted or the load data returns.
module lsu_bus_ctrl (
    input  logic                clk,
    input  logic                rst,
    input  logic                lsu_valid_i,
    input  logic [31:0]         alu_res,
    input  logic [31:0]         store_data_i,
    input  logic [2:0]          mem_access_type,
    output logic                lsu_stall_o,
    output logic                lsu_done_o,
    output logic                misalign_o,
    output logic [31:0]         load_data_o,
    lsu_bus_ctrl_if.master      bus
);
    localparam logic [2:0] READ_BYTE  = 3'd1;
    localparam logic [2:0] READ_HALF  = 3'd2;
    localparam logic [2:0] READ_WORD  = 3'd3;
    localparam logic [2:0] WRITE_BYTE = 3'd4;
    localparam logic [2:0] WRITE_HALF = 3'd5;
    localparam logic [2:0] WRITE_WORD = 3'd6;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, DONE = 2'd3} state_t;

    function automatic logic [3:0] enc_wstrb(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] strb;
        case (size)
            SZ_BYTE: strb = 4'b0001 << a;
            SZ_HALF: strb = a[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] enc_wdata(input logic [1:0] size, input logic [31:0] s);
        logic [31:0] d;
        case (size)
            SZ_BYTE: d = {4{s[7:0]}};
            SZ_HALF: d = {2{s[15:0]}};
            default: d = s;
        endcase
        return d;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        we_q, we_d;
    logic        mis_q, mis_d;
    logic [31:0] load_q, load_d;

    logic        is_rd_s, is_wr_s, start_s, misal_s;
    logic [1:0]  size_s;

    // Decode the access type into direction, size and alignment.
    always_comb begin
        is_rd_s = 1'b0;
        is_wr_s = 1'b0;
        size_s  = SZ_WORD;
        case (mem_access_type)
            READ_BYTE:  begin is_rd_s = 1'b1; size_s = SZ_BYTE; end
            READ_HALF:  begin is_rd_s = 1'b1; size_s = SZ_HALF; end
            READ_WORD:  begin is_rd_s = 1'b1; size_s = SZ_WORD; end
            WRITE_BYTE: begin is_wr_s = 1'b1; size_s = SZ_BYTE; end
            WRITE_HALF: begin is_wr_s = 1'b1; size_s = SZ_HALF; end
            WRITE_WORD: begin is_wr_s = 1'b1; size_s = SZ_WORD; end
            default:    begin is_rd_s = 1'b0; is_wr_s = 1'b0; end
        endcase
        case (size_s)
            SZ_HALF: misal_s = alu_res[0];
            SZ_WORD: misal_s = (alu_res[1:0] != 2'b00);
            default: misal_s = 1'b0;
        endcase
        start_s = lsu_valid_i && (is_rd_s || is_wr_s);
    end

    // Next-state and transaction-register update.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        we_d    = we_q;
        mis_d   = mis_q;
        load_d  = load_q;
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    if (misal_s) begin
                        mis_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        mis_d   = 1'b0;
                        addr_d  = {alu_res[31:2], 2'b00};
                        we_d    = is_wr_s;
                        wdata_d = is_wr_s ? enc_wdata(size_s, store_data_i) : 32'h0000_0000;
                        wstrb_d = is_wr_s ? enc_wstrb(size_s, alu_res[1:0]) : 4'b0000;
                        state_d = REQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                // Stores are posted: the grant alone completes them.
                if (bus.bus_gnt_i) begin
                    state_d = we_q ? DONE : RESP;
                end else begin
                    state_d = REQ;
                end
            end
            RESP: begin
                if (bus.bus_rvalid_i) begin
                    load_d  = bus.bus_rdata_i;
                    state_d = DONE;
                end else begin
                    state_d = RESP;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and transaction registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            wstrb_q <= 4'b0000;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            load_q  <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            we_q    <= we_d;
            mis_q   <= mis_d;
            load_q  <= load_d;
        end
    end

    // Outputs decode straight from registered state; stall also sees start in IDLE.
    always_comb begin
        lsu_stall_o     = ((state_q == IDLE) && start_s) || (state_q == REQ) || (state_q == RESP);
        lsu_done_o      = (state_q == DONE);
        misalign_o      = (state_q == DONE) && mis_q;
        load_data_o     = load_q;
        bus.bus_req_o   = (state_q == REQ);
        bus.bus_we_o    = we_q;
        bus.bus_addr_o  = addr_q;
        bus.bus_wdata_o = wdata_q;
        bus.bus_wstrb_o = wstrb_q;
    end
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed scoreboard bench: stimulus pushes expected bus beats and completions,
// a negedge monitor pops and compares them as the controller presents them.
module tb_lsu_bus_ctrl;
    localparam logic [2:0] RB = 3'd1, RH = 3'd2, RW = 3'd3;
    localparam logic [2:0] WB = 3'd4, WH = 3'd5, WW = 3'd6;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          req_cycles;
    } bus_exp_t;

    typedef struct {
        logic        mis;
        logic [31:0] load;
        int          stall_cycles;
    } done_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_valid_i = 1'b0;
    logic [31:0] alu_res = 32'h0;
    logic [31:0] store_data_i = 32'h0;
    logic [2:0]  mem_access_type = 3'd0;
    logic        lsu_stall_o, lsu_done_o, misalign_o;
    logic [31:0] load_data_o;

    lsu_bus_ctrl_if bus_if ();

    lsu_bus_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .lsu_valid_i     (lsu_valid_i),
        .alu_res         (alu_res),
        .store_data_i    (store_data_i),
        .mem_access_type (mem_access_type),
        .lsu_stall_o     (lsu_stall_o),
        .lsu_done_o      (lsu_done_o),
        .misalign_o      (misalign_o),
        .load_data_o     (load_data_o),
        .bus             (bus_if)
    );

    always #5 clk = ~clk;

    bus_exp_t  bus_q[$];
    done_exp_t done_q[$];
    int n_vec = 0;
    int n_err = 0;
    int n_txn = 0;
    int exp_txn = 0;
    logic [31:0] exp_load = 32'h0;

    // responder configuration
    int          g_dly = 0;
    int          r_dly = 1;
    logic [31:0] r_data = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: grant after g_dly waiting cycles, rvalid r_dly cycles after a load grant.
    initial begin
        int req_cnt = 0;
        int rv_cnt = 0;
        bus_if.bus_gnt_i    = 1'b0;
        bus_if.bus_rvalid_i = 1'b0;
        bus_if.bus_rdata_i  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus_if.bus_gnt_i    = 1'b0;
            bus_if.bus_rvalid_i = 1'b0;
            bus_if.bus_rdata_i  = 32'h0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    bus_if.bus_rvalid_i = 1'b1;
                    bus_if.bus_rdata_i  = r_data;
                end
            end else if (bus_if.bus_req_o && !rst) begin
                if (req_cnt == g_dly) begin
                    bus_if.bus_gnt_i = 1'b1;
                    req_cnt = 0;
                    if (!bus_if.bus_we_o) rv_cnt = r_dly;
                end else begin
                    req_cnt++;
                end
            end
        end
    end

    // Monitor: compare bus beats every request cycle and completions on each done pulse.
    initial begin
        int stall_cnt = 0;
        int req_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_cnt = 0;
                req_cyc = 0;
            end else begin
                if (lsu_stall_o) stall_cnt++;
                if (bus_if.bus_req_o) begin
                    req_cyc++;
                    if (bus_q.size() == 0) begin
                        chk("unexpected_req", 32'(bus_if.bus_req_o), 32'h0);
                    end else begin
                        chk("bus_we",    32'(bus_if.bus_we_o),    32'(bus_q[0].we));
                        chk("bus_addr",  bus_if.bus_addr_o,       bus_q[0].addr);
                        chk("bus_wdata", bus_if.bus_wdata_o,      bus_q[0].wdata);
                        chk("bus_wstrb", 32'(bus_if.bus_wstrb_o), 32'(bus_q[0].wstrb));
                        if (bus_if.bus_gnt_i) begin
                            chk("req_cycles", 32'(req_cyc), 32'(bus_q[0].req_cycles));
                            void'(bus_q.pop_front());
                            req_cyc = 0;
                            n_txn++;
                        end
                    end
                end
                if (lsu_done_o) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected_done", 32'(lsu_done_o), 32'h0);
                    end else begin
                        chk("misalign",     32'(misalign_o),  32'(done_q[0].mis));
                        chk("load_data",    load_data_o,      done_q[0].load);
                        chk("stall_cycles", 32'(stall_cnt),   32'(done_q[0].stall_cycles));
                        chk("stall_in_done", 32'(lsu_stall_o), 32'h0);
                        void'(done_q.pop_front());
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    // Present one access starting in the current IDLE cycle and wait for its done pulse.
    task automatic access(input logic [2:0] ty, input logic [31:0] a, input logic [31:0] s,
                          input int gd, input int rd, input logic [31:0] rdat,
                          input logic exp_mis, input logic [31:0] exp_wd, input logic [3:0] exp_ws);
        bus_exp_t  be;
        done_exp_t de;
        logic      is_wr;
        bit        seen = 1'b0;
        is_wr = (ty >= WB);
        @(posedge clk);
        #1;
        lsu_valid_i = 1'b1;
        mem_access_type = ty;
        alu_res = a;
        store_data_i = s;
        g_dly = gd;
        r_dly = rd;
        r_data = rdat;
        if (exp_mis) begin
            de.stall_cycles = 1;
        end else begin
            be.we = is_wr;
            be.addr = {a[31:2], 2'b00};
            be.wdata = is_wr ? exp_wd : 32'h0;
            be.wstrb = is_wr ? exp_ws : 4'b0000;
            be.req_cycles = gd + 1;
            bus_q.push_back(be);
            exp_txn++;
            if (!is_wr) exp_load = rdat;
            de.stall_cycles = is_wr ? (2 + gd) : (2 + gd + rd);
        end
        de.mis = exp_mis;
        de.load = exp_load;
        done_q.push_back(de);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (lsu_done_o) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        bit got_gnt = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall",  32'(lsu_stall_o), 32'h0);
        chk("rst_done",   32'(lsu_done_o), 32'h0);
        chk("rst_mis",    32'(misalign_o), 32'h0);
        chk("rst_req",    32'(bus_if.bus_req_o), 32'h0);
        chk("rst_we",     32'(bus_if.bus_we_o), 32'h0);
        chk("rst_addr",   bus_if.bus_addr_o, 32'h0);
        chk("rst_wdata",  bus_if.bus_wdata_o, 32'h0);
        chk("rst_wstrb",  32'(bus_if.bus_wstrb_o), 32'h0);
        chk("rst_load",   load_data_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        //     type addr          store data    gd rd rdata         mis  wdata         wstrb
        access(WB, 32'h0000_1003, 32'h0000_00A5, 0, 1, 32'h0,        1'b0, 32'hA5A5_A5A5, 4'b1000);
        access(RW, 32'h0000_2000, 32'h0,         3, 2, 32'hDEAD_BEEF, 1'b0, 32'h0,        4'b0000);
        access(RH, 32'h0000_2001, 32'h0,         0, 1, 32'h0,        1'b1, 32'h0,        4'b0000);
        access(WH, 32'h0000_3002, 32'h1234_BEEF, 0, 1, 32'h0,        1'b0, 32'hBEEF_BEEF, 4'b1100);
        access(RB, 32'h0000_4001, 32'h0,         0, 1, 32'h1122_3344, 1'b0, 32'h0,        4'b0000);
        access(WW, 32'h0000_5004, 32'hCAFE_F00D, 1, 1, 32'h0,        1'b0, 32'hCAFE_F00D, 4'b1111);
        access(RW, 32'h0000_6002, 32'h0,         0, 1, 32'h0,        1'b1, 32'h0,        4'b0000);
        access(WB, 32'h0000_7000, 32'h0000_005A, 2, 1, 32'h0,        1'b0, 32'h5A5A_5A5A, 4'b0001);
        access(WH, 32'h0000_3000, 32'h0000_8765, 0, 1, 32'h0,        1'b0, 32'h8765_8765, 4'b0011);
        access(WW, 32'h0000_3001, 32'h1111_1111, 0, 1, 32'h0,        1'b1, 32'h0,        4'b0000);
        access(RB, 32'h0000_9003, 32'h0,         1, 3, 32'h5566_7788, 1'b0, 32'h0,        4'b0000);

        // non-access encodings must not stall or start anything
        @(posedge clk);
        #1;
        mem_access_type = 3'd0;
        @(negedge clk);
        chk("noacc0_stall", 32'(lsu_stall_o), 32'h0);
        @(posedge clk);
        #1;
        mem_access_type = 3'd7;
        @(negedge clk);
        chk("noacc7_stall", 32'(lsu_stall_o), 32'h0);
        repeat (2) @(posedge clk);
        chk("txn_count", 32'(n_txn), 32'(exp_txn));

        // reset in the second RESP cycle abandons the load
        @(posedge clk);
        #1;
        lsu_valid_i = 1'b1;
        mem_access_type = RW;
        alu_res = 32'h0000_8000;
        g_dly = 0;
        r_dly = 3;
        r_data = 32'h9999_9999;
        begin
            bus_exp_t be;
            be.we = 1'b0;
            be.addr = 32'h0000_8000;
            be.wdata = 32'h0;
            be.wstrb = 4'b0000;
            be.req_cycles = 1;
            bus_q.push_back(be);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.bus_gnt_i) begin
                got_gnt = 1'b1;
                break;
            end
        end
        if (!got_gnt) chk("rst_test_gnt_timeout", 32'h0, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        lsu_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_req",   32'(bus_if.bus_req_o), 32'h0);
        chk("postrst_stall", 32'(lsu_stall_o), 32'h0);
        chk("postrst_load",  load_data_o, 32'h0);
        chk("postrst_late_rvalid_seen", 32'(bus_if.bus_rvalid_i), 32'h1);
        repeat (3) @(negedge clk);
        chk("late_rvalid_load", load_data_o, 32'h0);
        chk("late_rvalid_done", 32'(lsu_done_o), 32'h0);
        chk("bus_q_empty",  32'(bus_q.size()), 32'h0);
        chk("done_q_empty", 32'(done_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
